ldmstm_sequencer: RTL
=====================

// Module: ldmstm_sequencer
// PURPOSE
//  Multi-cycle sequencer for ARM block data transfers (LDM/STM). Decode supplies the instruction word and
//  the Rn value (op0) in one cycle. This block expands the register list into one transfer per cycle,
//  each with its own word address. It then issues the base writeback.
//  While it runs, it holds fetch and decode in busy.
// PARAMETERS
//  STEP  4  byte increment between consecutive transfer addresses
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  insn_valid  in   1   insn/base valid this cycle
//  insn        in   32  instruction word
//  base        in   32  current Rn value
//  stall       in   1   downstream cannot take the transfer this cycle
//  busy        out  1   sequencer occupied; upstream must hold
//  xfer_valid  out  1   transfer presented
//  xfer_reg    out  4   register number for this transfer
//  xfer_addr   out  32  word address for this transfer
//  xfer_load   out  1   1 = LDM (insn[20]); 0 = STM
//  xfer_user   out  1   S bit (insn[22]), passed through unchanged
//  xfer_last   out  1   this is the final transfer of the list
//  wb_valid    out  1   base writeback presented
//  wb_reg      out  4   Rn (insn[19:16])
//  wb_data     out  32  new base value
//  done        out  1   one-cycle pulse as the sequencer returns to IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. busy, xfer_valid, xfer_last, wb_valid, done=0. xfer_reg/addr, wb_reg/data=0.
//  - States: IDLE -> XFER -> (WB if W) -> IDLE. busy = (state != IDLE), taken from the registered state.
//  - Accept: in IDLE when insn_valid=1 and insn[27:25]==3'b100. Any other word is ignored.
//    insn_valid while busy is ignored.
//  - On accept, capture: list=insn[15:0]; P=insn[24], U=insn[23], W=insn[21], L, S, Rn; n=popcount(list).
//  - Start address, computed in 32-bit modulo arithmetic:
//      IA (P0U1): base
//      IB (P1U1): base+STEP
//      DA (P0U0): base-STEP*n+STEP
//      DB (P1U0): base-STEP*n
//  - Writeback value: U ? base+STEP*n : base-STEP*n.
//  - Latency: accept in cycle N. The first xfer_valid is at N+1.
//  - XFER ordering: registers go out in ascending number order, with ascending addresses. xfer_reg is the
//    lowest set bit of the remaining list.
//  - XFER advance: on a cycle with xfer_valid & !stall, clear that bit and add STEP to xfer_addr.
//  - XFER stall: while stall=1, every xfer_* output holds its value.
//  - xfer_last = 1 when exactly one bit of the list remains.
//  - Exit from XFER: after the last transfer is taken, go to WB if W=1, else to IDLE with done=1.
//  - WB lasts exactly one cycle: wb_valid=1, not gated by stall. The next cycle is IDLE with done=1.
//  - Empty list (n=0): no transfers. Go straight to WB (wb_data=base) if W=1, else IDLE.
//    done pulses either way, at N+2 or N+1 respectively.
//  - Rn inside the list: no special handling. Ordering and wb_data are unchanged; hazard policy is
//    handled downstream.
//  - Back-to-back: a new instruction can be accepted in the same cycle done=1, since state is IDLE then.
//  - Reset mid-operation: return to IDLE with all outputs at their reset values the next cycle.
//    No writeback is issued.
// TESTING
//  1. LDMIA r0!,{r1,r3}, base=0x1000 ->
//     xfer r1@0x1000, then r3@0x1004 (xfer_last=1, load=1), then wb r0=0x1008, then done.
//  2. STMDB r13!,{r4-r6}, base=0x2000 ->
//     r4@0x1FF4, r5@0x1FF8, r6@0x1FFC, then wb r13=0x1FF4, load=0.
//  3. LDMIB r2,{r0-r15}, base=0 ->
//     16 transfers r0@0x4 .. r15@0x40, xfer_last only on r15, no wb_valid, done at N+17.
//  4. LDMDA r1,{r7}, base=0x100 with stall=1 for 3 cycles ->
//     r7@0x100 held for those 3 cycles, taken on the first unstalled cycle.
//  5. Empty list with W=1, base=0x55 ->
//     no xfer_valid, wb_data=0x55 at N+1, done at N+2.
//  6. rst asserted on the 2nd transfer of a 4-register STMIA ->
//     IDLE next cycle, all outputs 0, no wb_valid.
//     A new insn_valid the following cycle is accepted normally.

Source files
------------

// File: rtl/ldmstm_sequencer.sv
// Expands an LDM/STM register list into one addressed transfer per cycle,
// followed by an optional base writeback; holds upstream busy while running.
module ldmstm_sequencer #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        insn_valid,
  input  logic [31:0] insn,
  input  logic [31:0] base,
  input  logic        stall,
  output logic        busy,
  output logic        xfer_valid,
  output logic [3:0]  xfer_reg,
  output logic [31:0] xfer_addr,
  output logic        xfer_load,
  output logic        xfer_user,
  output logic        xfer_last,
  output logic        wb_valid,
  output logic [3:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        done
);

  localparam int unsigned LIST_W = 16;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t              state;
  logic [LIST_W-1:0]   list;
  logic                wb_en;

  logic                accept_c;
  logic [CNT_W-1:0]    n_c;
  logic [31:0]         span_c;
  logic [31:0]         start_addr_c;
  logic [31:0]         wb_data_c;
  logic [LIST_W-1:0]   rest_c;
  logic                unused_cond;

  function automatic logic [3:0] lowest_set(input logic [LIST_W-1:0] v);
    lowest_set = 4'd0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < LIST_W; i++) begin
      popcount = popcount + CNT_W'(v[i]);
    end
  endfunction

  assign unused_cond = ^insn[31:28];

  // Decode-side address math: start address from P/U, writeback from U.
  always_comb begin
    accept_c = insn_valid && (insn[27:25] == 3'b100);
    n_c      = popcount(insn[15:0]);
    span_c   = 32'(STEP) * 32'(n_c);
    case ({insn[24], insn[23]})
      2'b01:   start_addr_c = base;
      2'b11:   start_addr_c = base + 32'(STEP);
      2'b00:   start_addr_c = base - span_c + 32'(STEP);
      default: start_addr_c = base - span_c;
    endcase
    wb_data_c = insn[23] ? (base + span_c) : (base - span_c);
    // Clearing the lowest set bit retires the register just transferred.
    rest_c    = list & (list - LIST_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      list       <= '0;
      wb_en      <= 1'b0;
      busy       <= 1'b0;
      xfer_valid <= 1'b0;
      xfer_reg   <= '0;
      xfer_addr  <= '0;
      xfer_load  <= 1'b0;
      xfer_user  <= 1'b0;
      xfer_last  <= 1'b0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            list      <= insn[15:0];
            wb_en     <= insn[21];
            xfer_load <= insn[20];
            xfer_user <= insn[22];
            wb_reg    <= insn[19:16];
            wb_data   <= wb_data_c;
            xfer_addr <= start_addr_c;
            xfer_reg  <= lowest_set(insn[15:0]);
            if (n_c != '0) begin
              state      <= XFER;
              busy       <= 1'b1;
              xfer_valid <= 1'b1;
              xfer_last  <= (n_c == CNT_W'(1));
            end else if (insn[21]) begin
              state    <= WB;
              busy     <= 1'b1;
              wb_valid <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        XFER: begin
          if (!stall) begin
            list <= rest_c;
            if (rest_c == '0) begin
              xfer_valid <= 1'b0;
              xfer_last  <= 1'b0;
              if (wb_en) begin
                state    <= WB;
                wb_valid <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              xfer_reg  <= lowest_set(rest_c);
              xfer_addr <= xfer_addr + 32'(STEP);
              xfer_last <= ((rest_c & (rest_c - LIST_W'(1))) == '0);
            end
          end
        end
        WB: begin
          wb_valid <= 1'b0;
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
